// File: rtl/xadc_sample_sequencer.sv
// xadc_sample_sequencer
//   Reads two XADC auxiliary channels over the DRP port once per sample
//   period. It averages 2^AVG_LOG2 rounds per channel and publishes the
//   12-bit averages, an 8-bit light value and a status byte for the MCU
//   input-port mux.
//
// Optional feature macro: XADC_SEQ_TIMEOUT_EN
//   Defined   : a wait for DRP_DRDY longer than TIMEOUT_CYC cycles aborts the
//               round and sets the sticky TIMEOUT_ERR flag.
//   Undefined : the FSM waits for DRP_DRDY indefinitely; TIMEOUT_ERR reads 0.
//
// Ports
//   CLK, RESET_N          clock, asynchronous active-low reset
//   DRP_DEN, DRP_DADDR    DRP read request (one-cycle DEN, address held to DRDY)
//   DRP_DRDY, DRP_DO      DRP read response; conversion result in DO[15:4]
//   ENABLE                1 = start rounds on period ticks
//   STATUS_ACK            clears the NEW/OVERRUN/TIMEOUT_ERR sticky flags
//   CH0_DATA, CH1_DATA    published averages
//   LIGHT_OUT             CH0_DATA[11:4]
//   PUB_STB               one-cycle pulse when the averages update
//   STATUS                {NEW, OVERRUN, TIMEOUT_ERR, 2'b00, BUSY, round_cnt[1:0]}
//   DBG_STATE             current FSM state encoding (debug observation)
//
// Handshake: a DRP read is issued by a one-cycle DRP_DEN with DRP_DADDR; the
// address stays stable until the single-cycle DRP_DRDY response, which is
// only accepted in the matching wait state and ignored everywhere else.
module xadc_sample_sequencer #(
  parameter int unsigned SAMPLE_PERIOD = 100000,
  parameter int unsigned AVG_LOG2      = 3,
  parameter logic [6:0]  CH0_ADDR      = 7'h16,
  parameter logic [6:0]  CH1_ADDR      = 7'h17,
  parameter int unsigned TIMEOUT_CYC   = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        DRP_DEN,
  output logic [6:0]  DRP_DADDR,
  input  logic        DRP_DRDY,
  input  logic [15:0] DRP_DO,
  input  logic        ENABLE,
  input  logic        STATUS_ACK,
  output logic [11:0] CH0_DATA,
  output logic [11:0] CH1_DATA,
  output logic [7:0]  LIGHT_OUT,
  output logic        PUB_STB,
  output logic [7:0]  STATUS,
  output logic [2:0]  DBG_STATE
);

  if (SAMPLE_PERIOD < 64 || SAMPLE_PERIOD > 32'h00FF_FFFF || AVG_LOG2 > 6 ||
      TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535) begin : g_param_check
    $error("xadc_sample_sequencer: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_ROUND = 3'd5
  } state_e;

  localparam logic [23:0] PERIOD_LAST = 24'(SAMPLE_PERIOD - 1);
  localparam logic [5:0]  ROUND_LAST  = 6'((1 << AVG_LOG2) - 1);

  state_e      state_q, state_d;
  logic [23:0] per_q, per_d;
  logic [17:0] acc0_q, acc0_d, acc1_q, acc1_d;
  logic [5:0]  rc_q, rc_d;
  logic [11:0] ch0_q, ch0_d, ch1_q, ch1_d;
  logic        pub_q, pub_d;
  logic        new_q, new_d, ovr_q, ovr_d;
  logic        tmo_err;
  logic        tick, busy;
  logic        unused_do;

  // The low nibble of DO is below the 12-bit conversion result.
  assign unused_do = ^DRP_DO[3:0];

  assign tick = ENABLE && (per_q == PERIOD_LAST);
  assign busy = (state_q != S_IDLE);

`ifdef XADC_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] tcnt_q, tcnt_d;
  logic        tmo_q, tmo_d;
  assign tmo_err = tmo_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      tcnt_q <= 16'd0;
      tmo_q  <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      tmo_q  <= tmo_d;
    end
  end
`else
  assign tmo_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc0_d  = acc0_q;
    acc1_d  = acc1_q;
    rc_d    = rc_q;
    ch0_d   = ch0_q;
    ch1_d   = ch1_q;
    pub_d   = 1'b0;
    new_d   = STATUS_ACK ? 1'b0 : new_q;
    ovr_d   = STATUS_ACK ? 1'b0 : ovr_q;
`ifdef XADC_SEQ_TIMEOUT_EN
    tcnt_d  = 16'd0;
    tmo_d   = STATUS_ACK ? 1'b0 : tmo_q;
`endif

    // Period counter holds at 0 while disabled so re-enabling restarts a full period.
    if (!ENABLE || per_q == PERIOD_LAST) per_d = 24'd0;
    else                                 per_d = per_q + 24'd1;

    // Set events are applied after the ACK clear so a coincident set wins.
    if (tick && busy) ovr_d = 1'b1;

    case (state_q)
      S_IDLE:  if (tick) state_d = S_REQ0;
      S_REQ0:  state_d = S_WAIT0;
      S_WAIT0: if (DRP_DRDY) begin
                 acc0_d  = acc0_q + {6'd0, DRP_DO[15:4]};
                 state_d = S_REQ1;
               end
      S_REQ1:  state_d = S_WAIT1;
      S_WAIT1: if (DRP_DRDY) begin
                 acc1_d  = acc1_q + {6'd0, DRP_DO[15:4]};
                 state_d = S_ROUND;
               end
      S_ROUND: begin
                 state_d = S_IDLE;
                 rc_d    = rc_q + 6'd1;
                 if (rc_q == ROUND_LAST) begin
                   ch0_d  = 12'(acc0_q >> AVG_LOG2);
                   ch1_d  = 12'(acc1_q >> AVG_LOG2);
                   pub_d  = 1'b1;
                   new_d  = 1'b1;
                   acc0_d = 18'd0;
                   acc1_d = 18'd0;
                   rc_d   = 6'd0;
                 end
               end
      default: state_d = S_IDLE;
    endcase

`ifdef XADC_SEQ_TIMEOUT_EN
    // Abort the whole round: partial accumulations would skew the average.
    if ((state_q == S_WAIT0 || state_q == S_WAIT1) && !DRP_DRDY) begin
      if (tcnt_q == TMO_LAST) begin
        tmo_d   = 1'b1;
        acc0_d  = 18'd0;
        acc1_d  = 18'd0;
        rc_d    = 6'd0;
        state_d = S_IDLE;
      end else begin
        tcnt_d = tcnt_q + 16'd1;
      end
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      per_q   <= 24'd0;
      acc0_q  <= 18'd0;
      acc1_q  <= 18'd0;
      rc_q    <= 6'd0;
      ch0_q   <= 12'd0;
      ch1_q   <= 12'd0;
      pub_q   <= 1'b0;
      new_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      rc_q    <= rc_d;
      ch0_q   <= ch0_d;
      ch1_q   <= ch1_d;
      pub_q   <= pub_d;
      new_q   <= new_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    DRP_DADDR = 7'd0;
    if (state_q == S_REQ0 || state_q == S_WAIT0) DRP_DADDR = CH0_ADDR;
    if (state_q == S_REQ1 || state_q == S_WAIT1) DRP_DADDR = CH1_ADDR;
  end

  assign DRP_DEN   = (state_q == S_REQ0) || (state_q == S_REQ1);
  assign CH0_DATA  = ch0_q;
  assign CH1_DATA  = ch1_q;
  assign LIGHT_OUT = ch0_q[11:4];
  assign PUB_STB   = pub_q;
  assign STATUS    = {new_q, ovr_q, tmo_err, 2'b00, busy, rc_q[1:0]};
  assign DBG_STATE = state_q;

endmodule

// File: doc/xadc_sample_sequencer.md
Name: xadc_sample_sequencer

Overview:
- Periodically reads two XADC auxiliary channels through the XADC DRP port: the light sensor and a spare channel.
- Averages 2^AVG_LOG2 conversions per channel and publishes 12-bit results plus an 8-bit scaled light value.
- The 8-bit value and a status byte are for the RAT MCU input-port mux.
- Sits between the XADC primitive and the SolarRAT driver. It replaces the free-running XADC read path, so software sees stable, averaged, flagged samples.

Parameters:
- SAMPLE_PERIOD, 100000: CLK cycles between round starts (1 ms at 100 MHz); legal range 64..2^24-1.
- AVG_LOG2, 3: log2 of rounds averaged per publish; legal range 0..6.
- CH0_ADDR, 7'h16: DRP address of channel 0 (VAUX6, light sensor).
- CH1_ADDR, 7'h17: DRP address of channel 1 (VAUX7).
- TIMEOUT_CYC, 255: maximum cycles to wait for DRDY (used only with the optional feature).

Ports:
- CLK  in  1  system clock (100 MHz)
- RESET_N  in  1  asynchronous active-low reset
- DRP_DEN  out  1  DRP enable, one-cycle pulse per read
- DRP_DADDR  out  7  DRP address, valid while DRP_DEN=1 and held until DRDY
- DRP_DRDY  in  1  DRP read data valid
- DRP_DO  in  16  DRP read data; conversion result is in bits [15:4]
- ENABLE  in  1  1 = sequencing allowed; 0 = finish the current read, then idle
- STATUS_ACK  in  1  one-cycle pulse from the MCU port write; clears sticky flags and NEW
- CH0_DATA  out  12  latest published channel-0 average
- CH1_DATA  out  12  latest published channel-1 average
- LIGHT_OUT  out  8  CH0_DATA[11:4]
- PUB_STB  out  1  one-cycle pulse when CH0_DATA/CH1_DATA update
- STATUS  out  8  {NEW, OVERRUN, TIMEOUT_ERR, 2'b00, BUSY, round_cnt[1:0]}

Behaviour:
- Reset, asynchronous: all outputs 0, FSM in IDLE, period counter 0, accumulators 0, round counter 0.
- Period counter: free-runs 0..SAMPLE_PERIOD-1 while ENABLE=1 and holds at 0 while ENABLE=0. The terminal count produces an internal tick.
- A tick while the FSM is not IDLE is dropped and sets sticky OVERRUN.
- FSM states:
  - IDLE: on tick with ENABLE=1, go to REQ0.
  - REQ0: DRP_DEN=1 and DRP_DADDR=CH0_ADDR for exactly one cycle, then WAIT0.
  - WAIT0: hold DRP_DADDR. On DRP_DRDY, acc0 += DRP_DO[15:4], then REQ1.
  - REQ1 and WAIT1: same as REQ0/WAIT0 with CH1_ADDR and acc1.
  - After WAIT1, go to ROUND.
  - ROUND: round_cnt += 1.
    - If round_cnt was 2^AVG_LOG2-1: CH0_DATA = acc0 >> AVG_LOG2, CH1_DATA = acc1 >> AVG_LOG2; PUB_STB=1 for one cycle; NEW=1; accumulators and round_cnt cleared.
    - In all cases the next state is IDLE.
- Accumulators are 18 bits wide (12 + 6), so they never overflow. Division is a truncating shift.
- With AVG_LOG2=0, every round publishes.
- DRP_DRDY arriving outside WAIT0/WAIT1 is ignored.
- BUSY = 1 in every state other than IDLE.
- ENABLE falling mid-round: the current round completes, including any publish. No new round starts.
- STATUS_ACK clears NEW, OVERRUN and TIMEOUT_ERR in the next cycle. If a set event occurs in the same cycle as STATUS_ACK, the set wins.
- Latency: tick to PUB_STB = 2*(DRDY latency + 1) + 2 cycles on a publishing round.

Optional Feature:
- Macro: XADC_SEQ_TIMEOUT_EN.
- Defined:
  - WAIT0 and WAIT1 count cycles. If TIMEOUT_CYC cycles elapse without DRP_DRDY, sticky TIMEOUT_ERR is set.
  - The round is aborted: accumulators and round_cnt are cleared, nothing is published, and the FSM returns to IDLE.
- Undefined:
  - No counter exists and the FSM waits indefinitely.
  - TIMEOUT_ERR is tied to 0 and the TIMEOUT_CYC parameter is ignored.

Test Plan:
- Averaging: AVG_LOG2=2, SAMPLE_PERIOD=64, DRDY model with 3-cycle latency returning CH0 DO=16'h8000 and CH1 DO=16'h1230 -> after 4 rounds, one PUB_STB, CH0_DATA=12'h800, CH1_DATA=12'h123, LIGHT_OUT=8'h80, NEW=1.
- Truncation: CH0 samples 12'h001,002,003,004 with AVG_LOG2=2 -> CH0_DATA=12'h002. With AVG_LOG2=0 -> PUB_STB every round.
- Overrun: DRDY latency 40 with SAMPLE_PERIOD=64 -> ticks land while busy, so OVERRUN=1. STATUS_ACK pulse -> OVERRUN=0 next cycle. STATUS_ACK in the same cycle as a publish -> NEW stays 1.
- Timeout (macro defined, TIMEOUT_CYC=20): DRDY never asserted for CH1 -> TIMEOUT_ERR=1 at cycle 20 of WAIT1, FSM back in IDLE, no PUB_STB, next round works normally. Macro undefined -> FSM stays in WAIT1 with BUSY=1.
- Reset mid-WAIT0: RESET_N low for 1 cycle -> all outputs 0 and DRP_DEN=0 immediately. A late DRDY after reset is ignored.
- ENABLE deasserted during REQ1 -> round completes and BUSY falls. No further DRP_DEN while ENABLE=0. Period counter restarts from 0 when ENABLE returns.
